regfile_wr_arbiter: RTL and testbench



---
 rtl/regfile_wr_arbiter.sv | 92 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file write port among writeback units.
// The granted write is staged one cycle and forwarded to the read ports.
module regfile_wr_arbiter #(
  parameter int N_REQ         = 3,
  parameter int N_ENTRIES     = 32,
  parameter int ENTRY_WIDTH   = 32,
  parameter int N_READ_PORTS  = 2,
  parameter bit HARDWIRE_ZERO = 1'b1,
  localparam int PTR_WIDTH    = $clog2(N_ENTRIES)
) (
  input  logic                                      clk,
  input  logic                                      rst_aL,
  input  logic                                      stall,
  input  logic [N_REQ-1:0]                          req_valid,
  input  logic [N_REQ-1:0][PTR_WIDTH-1:0]           req_addr,
  input  logic [N_REQ-1:0][ENTRY_WIDTH-1:0]         req_data,
  output logic [N_REQ-1:0]                          req_ready,
  output logic                                      rf_wr_en,
  output logic [PTR_WIDTH-1:0]                      rf_wr_addr,
  output logic [ENTRY_WIDTH-1:0]                    rf_wr_data,
  input  logic [N_READ_PORTS-1:0][PTR_WIDTH-1:0]    rd_addr,
  input  logic [N_READ_PORTS-1:0][ENTRY_WIDTH-1:0]  rf_rd_data,
  output logic [N_READ_PORTS-1:0][ENTRY_WIDTH-1:0]  rd_data
);

  localparam int RR_W = $clog2(N_REQ);

  logic [RR_W-1:0]        rr_ptr;
  logic [RR_W-1:0]        grant_idx;
  logic                   grant_vld;
  logic                   stg_en;
  logic [PTR_WIDTH-1:0]   stg_addr;
  logic [ENTRY_WIDTH-1:0] stg_data;

  // Circular scan starting at rr_ptr; the first valid requester wins.
  always_comb begin : grant_scan
    int idx;
    // NOTE: every variable driven here gets a default before any branch,
    // otherwise synthesis infers a latch to hold the old value.
    grant_vld = 1'b0;
    grant_idx = '0;
    req_ready = '0;
    idx       = 0;
    if (rst_aL && !stall) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!grant_vld && req_valid[idx]) begin
          grant_vld = 1'b1;
          grant_idx = idx[RR_W-1:0];
        end
      end
    end
    if (grant_vld) req_ready[grant_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      rr_ptr   <= '0;
      stg_en   <= 1'b0;
      stg_addr <= '0;
      stg_data <= '0;
    end else begin
      stg_en <= 1'b0;
      if (grant_vld) begin
        rr_ptr   <= (grant_idx == RR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        stg_addr <= req_addr[grant_idx];
        stg_data <= req_data[grant_idx];
        // Writes to the hardwired zero register are accepted but dropped.
        stg_en   <= !(HARDWIRE_ZERO && (req_addr[grant_idx] == '0));
      end
    end
  end

  assign rf_wr_en   = stg_en;
  assign rf_wr_addr = stg_addr;
  assign rf_wr_data = stg_data;

  // Bypass the staged write so readers see it before the regfile commits it.
  always_comb begin
    rd_data = rf_rd_data;
    for (int p = 0; p < N_READ_PORTS; p++) begin
      if (HARDWIRE_ZERO && (rd_addr[p] == '0))
        rd_data[p] = '0;
      else if (stg_en && (stg_addr == rd_addr[p]))
        rd_data[p] = stg_data;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: a regfile-level model predicts grants,
// staged writes and architecturally visible read data; a monitor compares each cycle.
module tb_regfile_wr_arbiter;

  localparam int N  = 3;
  localparam int NE = 32;
  localparam int PW = 5;
  localparam int W  = 32;
  localparam int NR = 2;

  typedef struct packed {
    logic          en;
    logic [PW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  logic                   clk = 1'b0;
  logic                   rst_aL;
  logic                   stall;
  logic [N-1:0]           req_valid;
  logic [N-1:0][PW-1:0]   req_addr;
  logic [N-1:0][W-1:0]    req_data;
  logic [N-1:0]           req_ready;
  logic                   rf_wr_en;
  logic [PW-1:0]          rf_wr_addr;
  logic [W-1:0]           rf_wr_data;
  logic [NR-1:0][PW-1:0]  rd_addr;
  logic [NR-1:0][W-1:0]   rf_rd_data;
  logic [NR-1:0][W-1:0]   rd_data;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(
    .N_REQ(N), .N_ENTRIES(NE), .ENTRY_WIDTH(W), .N_READ_PORTS(NR), .HARDWIRE_ZERO(1'b1)
  ) dut (
    .clk(clk), .rst_aL(rst_aL), .stall(stall),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rd_addr(rd_addr), .rf_rd_data(rf_rd_data), .rd_data(rd_data)
  );

  // Environment: the register file the arbiter feeds (not reset, like real storage).
  logic [W-1:0] tb_rf [NE] = '{default: '0};
  always @(posedge clk) if (rf_wr_en) tb_rf[rf_wr_addr] <= rf_wr_data;
  always_comb for (int p = 0; p < NR; p++) rf_rd_data[p] = tb_rf[rd_addr[p]];

  // Reference model: architectural register contents as of each accepted write.
  logic [W-1:0]         shadow [NE] = '{default: '0};
  int                   rr_model;
  int                   prev_addr;
  logic [W-1:0]         prev_old;
  wr_t                  wr_q [$];
  logic [N-1:0]         rdy_q [$];
  logic [NR-1:0][W-1:0] rd_q [$];
  logic                 chk_en;
  int                   n_tests = 0;
  int                   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: apply inputs for this cycle and record what must happen.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0][PW-1:0] a,
                      input logic [N-1:0][W-1:0] d, input logic st,
                      input logic [NR-1:0][PW-1:0] ra);
    int g;
    logic [N-1:0] rdy;
    logic [NR-1:0][W-1:0] rexp;
    wr_t w;
    req_valid = v; req_addr = a; req_data = d; stall = st; rd_addr = ra;
    g = -1;
    if (!st)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(rr_model + k) % N]) g = (rr_model + k) % N;
    rdy = '0;
    if (g >= 0) rdy[g] = 1'b1;
    for (int p = 0; p < NR; p++) rexp[p] = (ra[p] == 0) ? '0 : shadow[ra[p]];
    w = '0;
    prev_addr = -1;
    if (g >= 0) begin
      w.en = (a[g] != 0);
      w.addr = a[g];
      w.data = d[g];
      if (w.en) begin
        prev_addr = int'(a[g]);
        prev_old = shadow[a[g]];
        shadow[a[g]] = d[g];
      end
      rr_model = (g + 1) % N;
    end
    rdy_q.push_back(rdy);
    rd_q.push_back(rexp);
    wr_q.push_back(w);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [NR-1:0][PW-1:0] ra);
    step('0, '0, '0, 1'b0, ra);
  endtask

  always @(negedge clk) begin : monitor
    logic [N-1:0] r;
    wr_t w;
    logic [NR-1:0][W-1:0] e;
    if (chk_en) begin
      if (rdy_q.size() == 0 || wr_q.size() == 0 || rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
      end else begin
        r = rdy_q.pop_front();
        w = wr_q.pop_front();
        e = rd_q.pop_front();
        check("req_ready", 64'(req_ready), 64'(r));
        check("rf_wr_en", 64'(rf_wr_en), 64'(w.en));
        if (w.en) begin
          check("rf_wr_addr", 64'(rf_wr_addr), 64'(w.addr));
          check("rf_wr_data", 64'(rf_wr_data), 64'(w.data));
        end
        for (int p = 0; p < NR; p++) check($sformatf("rd_data[%0d]", p), 64'(rd_data[p]), 64'(e[p]));
      end
    end
  end

  initial begin
    logic [N-1:0][PW-1:0] a;
    logic [N-1:0][W-1:0]  d;
    logic [NR-1:0][PW-1:0] ra;
    logic [W-1:0] saved9;

    chk_en = 1'b0; rr_model = 0; prev_addr = -1; prev_old = '0;
    rst_aL = 1'b0; stall = 1'b0; req_valid = '1;
    req_addr = '0; req_data = '1; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_wr_en", 64'(rf_wr_en), 64'd0);
    check("reset_rf_wr_addr", 64'(rf_wr_addr), 64'd0);
    check("reset_rf_wr_data", 64'(rf_wr_data), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    req_valid = '0;
    rst_aL = 1'b1;
    @(posedge clk);
    #1;
    wr_q.push_back('0);
    chk_en = 1'b1;

    // All three requesting distinct addresses: grants rotate and the pointer wraps.
    a = {5'd7, 5'd6, 5'd5};
    d = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    ra = {5'd6, 5'd5};
    repeat (6) step(3'b111, a, d, 1'b0, ra);

    // Single write forwarded before the regfile holds it, then read directly.
    a = '0; d = '0; a[1] = 5'd3; d[1] = 32'h1234_5678;
    step(3'b010, a, d, 1'b0, '0);
    ra = '0; ra[0] = 5'd3;
    idle(ra);
    idle(ra);

    // Write to register 0 is accepted but never reaches the regfile.
    a = '0; d = '0; d[0] = 32'hDEAD_BEEF;
    ra = '0;
    step(3'b001, a, d, 1'b0, ra);
    idle(ra);

    // Stall blocks all grants and holds the pointer.
    a = {5'd12, 5'd11, 5'd10};
    d = {32'h3, 32'h2, 32'h1};
    repeat (3) step(3'b011, a, d, 1'b1, ra);
    step(3'b011, a, d, 1'b0, ra);
    step(3'b011, a, d, 1'b0, ra);
    idle(ra);

    // Back-to-back writes to one address from different requesters.
    a = {5'd0, 5'd4, 5'd4};
    d = {32'h0, 32'h2, 32'h1};
    ra = '0; ra[0] = 5'd4;
    step(3'b001, a, d, 1'b0, ra);
    step(3'b010, a, d, 1'b0, ra);
    idle(ra);
    idle(ra);
    check("rf4_final", 64'(tb_rf[4]), 64'd2);

    // Randomised traffic over a small address range to provoke hazards.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        a[i] = PW'($urandom_range(0, 7));
        d[i] = $urandom;
      end
      for (int p = 0; p < NR; p++) ra[p] = PW'($urandom_range(0, 7));
      step(N'($urandom), a, d, ($urandom_range(0, 9) == 0), ra);
    end
    idle('0);

    // Reset during the staging cycle discards the staged write.
    a = '0; d = '0; a[2] = 5'd9; d[2] = 32'h0000_00FF;
    saved9 = shadow[9];
    step(3'b100, a, d, 1'b0, '0);
    chk_en = 1'b0;
    req_valid = '0; stall = 1'b0; rd_addr = '0;
    #2;
    rst_aL = 1'b0;
    #1;
    check("midreset_rf_wr_en", 64'(rf_wr_en), 64'd0);
    check("midreset_req_ready", 64'(req_ready), 64'd0);
    rdy_q.delete(); wr_q.delete(); rd_q.delete();
    rr_model = 0;
    if (prev_addr >= 0) shadow[prev_addr] = prev_old;
    @(negedge clk);
    rst_aL = 1'b1;
    @(posedge clk);
    #1;
    check("rf9_unchanged", 64'(tb_rf[9]), 64'(saved9));
    wr_q.push_back('0);
    chk_en = 1'b1;
    a = {5'd14, 5'd13, 5'd9};
    d = {32'h77, 32'h66, 32'h55};
    ra = {5'd9, 5'd9};
    step(3'b111, a, d, 1'b0, ra);
    idle(ra);
    idle(ra);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
